cpu_step_core: RTL and testbench
================================

# cpu_step_core

Single-step CPU core that answers the front-panel debug controller. Each one-cycle `start` pulse makes the core execute exactly one 16-bit instruction through a fixed fetch/decode/execute/writeback sequence, then stop. While stopped, it exposes `pc`, `ir` and the packed register file so the debug display can show them. The core reads instructions through a combinational instruction-memory port and owns five 8-bit registers, R0..R4.

## Interface
Parameters:
- `RST_PC`, 8'h00, value loaded into `pc` on reset.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle step request from the debug button controller.
- `im_data`  in  16  instruction word at `im_addr`; combinational, valid in the same cycle.
- `im_addr`  out  8  instruction fetch address; always equals `pc`.
- `pc`  out  8  program counter.
- `ir`  out  16  instruction register; holds the last fetched instruction.
- `rf_data`  out  40  packed registers: R0=[7:0], R1=[15:8], R2=[23:16], R3=[31:24], R4=[39:32].
- `busy`  out  1  high while a step is in progress (FETCH..WB).
- `halted`  out  1  high once HLT has executed.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Transitions:
  - IDLE: start=1 → FETCH.
  - FETCH → DECODE → EXEC → WB, unconditionally.
  - WB → IDLE, or WB → HALT if the opcode is HLT.
  - HALT: stays in HALT until `rst`.
- FETCH: `ir <= im_data`.
- DECODE: latch operand values A and B from the register fields, plus the immediate.
- EXEC: compute the 8-bit result and the next pc.
- WB: write Rd (if the instruction writes) and load `pc`.
- Instruction format: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm=[7:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: Rd=imm.
  - 2 ADD: Rd=Rs+Rt.
  - 3 SUB: Rd=Rs−Rt.
  - 4 AND: Rd=Rs&Rt.
  - 5 OR: Rd=Rs|Rt.
  - 6 JMP: pc=imm.
  - 7 JZ: if R[rd]==0 then pc=imm, else pc+1.
  - F HLT: pc unchanged.
  - Opcodes 8..E execute as NOP.
- Arithmetic: 8-bit, modulo 256. No carry or flags are kept.
- PC: non-jump instructions set pc=pc+1, wrapping 8'hFF → 8'h00.
- Register indices 5..7: reads return 8'h00; writes are discarded.
- `start` asserted in any state other than IDLE is ignored. Pulses are not queued.

## Timing
- Reset values (asynchronous, take effect immediately):
  - pc=RST_PC, ir=16'h0000, R0..R4=8'h00, rf_data=40'h0.
  - busy=0, halted=0, state=IDLE.
- `start` sampled high in IDLE at edge k:
  - state=FETCH after k; busy rises after k.
  - `ir` updates at edge k+1.
  - `pc` and Rd update together at edge k+4.
  - busy falls after k+4.
- Step latency is 4 cycles. The earliest accepted next start is sampled at edge k+5.
- `halted` rises at edge k+4 of the HLT step. busy is 0 in HALT.
- `rst` asserted mid-step aborts the step: the partial instruction is discarded and no register or pc write occurs.
- `start` held high for several cycles produces exactly one step. It is only re-sampled once the core is back in IDLE, so a start still high at k+5 begins a new step.

## Configuration
- `CPU_FREE_RUN_EN` defined:
  - Adds input port `run` (1 bit).
  - While `run`=1, WB goes directly to FETCH instead of IDLE, giving one instruction every 4 cycles with busy held high.
  - When `run` drops, the core finishes the current instruction and returns to IDLE.
  - HLT still goes to HALT.
- Not defined: no `run` port; every instruction requires its own `start` pulse.

## Test plan
- Reset then LDI R1,8'h5A (16'h125A) with one start → ir=16'h125A at k+1; rf_data[15:8]=8'h5A and pc=8'h01 at k+4; busy high for exactly 4 cycles.
- R1=8'h05, R2=8'h07: SUB R3,R1,R2 (16'h3650) → R3=8'hFE. ADD with R1=8'hFF, R2=8'h01 → 8'h00.
- JZ R0,8'h40 with R0=0 → pc=8'h40. Same instruction with R0=8'h01 → pc=pc+1. Instruction at pc=8'hFF that is not a jump → pc=8'h00.
- start held high for 10 cycles → exactly two steps, accepted at edges k and k+5.
- HLT (16'hF000) → halted=1, pc unchanged, later starts ignored. rst asserted during EXEC of an ADD → all outputs return to reset values with no write.
- With `CPU_FREE_RUN_EN` and run=1: three LDIs complete at 4-cycle spacing. Dropping run stops the core in IDLE after the current WB.

Source files
------------

// File: rtl/cpu_step_core_if.sv
// Debug-panel bus between the front-panel controller (master) and cpu_step_core (slave).
// Optional macro CPU_FREE_RUN_EN adds the run request line.
interface cpu_step_core_if;
   localparam int unsigned IW = 16;
   localparam int unsigned AW = 8;
   localparam int unsigned RW = 40;

   logic          start;
   logic [IW-1:0] im_data;
   logic [AW-1:0] im_addr;
   logic [AW-1:0] pc;
   logic [IW-1:0] ir;
   logic [RW-1:0] rf_data;
   logic          busy;
   logic          halted;
`ifdef CPU_FREE_RUN_EN
   logic          run;

   modport master (output start, output run, output im_data,
                   input im_addr, input pc, input ir, input rf_data, input busy, input halted);
   modport slave  (input start, input run, input im_data,
                   output im_addr, output pc, output ir, output rf_data, output busy, output halted);
`else
   modport master (output start, output im_data,
                   input im_addr, input pc, input ir, input rf_data, input busy, input halted);
   modport slave  (input start, input im_data,
                   output im_addr, output pc, output ir, output rf_data, output busy, output halted);
`endif
endinterface

// File: rtl/cpu_step_core.sv
// Single-step CPU core: one start pulse runs FETCH/DECODE/EXEC/WB for one instruction.
// Optional macro CPU_FREE_RUN_EN: while run=1, WB chains straight into the next FETCH.
module cpu_step_core #(
   parameter logic [7:0] RST_PC = 8'h00
) (
   input logic            clk,
   input logic            rst,
   cpu_step_core_if.slave bus
);
   localparam int unsigned DW   = 8;
   localparam int unsigned IW   = 16;
   localparam int unsigned NREG = 5;

   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_e;

   state_e                   state_q, state_d;
   logic [DW-1:0]            pc_q, pc_d;
   logic [IW-1:0]            ir_q, ir_d;
   logic [NREG-1:0][DW-1:0]  rf_q, rf_d;
   logic [DW-1:0]            a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [DW-1:0]            res_q, res_d, npc_q, npc_d;
   logic                     busy_q, busy_d, halted_q, halted_d;
   logic                     run_c;

   logic [3:0] op;
   logic [2:0] rd, rs, rt;
   assign op = ir_q[15:12];
   assign rd = ir_q[11:9];
   assign rs = ir_q[8:6];
   assign rt = ir_q[5:3];

`ifdef CPU_FREE_RUN_EN
   assign run_c = bus.run;
`else
   assign run_c = 1'b0;
`endif

   // Register read with R5..R7 reading as zero.
   function automatic logic [DW-1:0] rd_reg(input logic [NREG-1:0][DW-1:0] rf,
                                             input logic [2:0] idx);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < int'(NREG); i++)
         if (idx == 3'(i)) v = rf[i];
      return v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RST_PC;
         ir_q     <= '0;
         rf_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         res_q    <= '0;
         npc_q    <= '0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         rf_q     <= rf_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         res_q    <= res_d;
         npc_q    <= npc_d;
         busy_q   <= busy_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      rf_d    = rf_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      res_d   = res_q;
      npc_d   = npc_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = bus.im_data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // JZ tests R[rd], so operand A comes from the rd field for it.
            a_d     = (op == OP_JZ) ? rd_reg(rf_q, rd) : rd_reg(rf_q, rs);
            b_d     = rd_reg(rf_q, rt);
            imm_d   = ir_q[7:0];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d = '0;
            npc_d = pc_q + 8'd1;
            case (op)
               OP_LDI:  res_d = imm_q;
               OP_ADD:  res_d = a_q + b_q;
               OP_SUB:  res_d = a_q - b_q;
               OP_AND:  res_d = a_q & b_q;
               OP_OR:   res_d = a_q | b_q;
               OP_JMP:  npc_d = imm_q;
               OP_JZ:   if (a_q == '0) npc_d = imm_q;
               OP_HLT:  npc_d = pc_q;
               default: ;
            endcase
            state_d = S_WB;
         end
         S_WB: begin
            pc_d = npc_q;
            if (op >= OP_LDI && op <= OP_OR)
               for (int i = 0; i < int'(NREG); i++)
                  if (rd == 3'(i)) rf_d[i] = res_q;
            if (op == OP_HLT)  state_d = S_HALT;
            else if (run_c)    state_d = S_FETCH;
            else               state_d = S_IDLE;
         end
         S_HALT:  ;
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_EXEC)  || (state_d == S_WB);
      halted_d = (state_d == S_HALT);
   end

   assign bus.im_addr = pc_q;
   assign bus.pc      = pc_q;
   assign bus.ir      = ir_q;
   assign bus.rf_data = rf_q;
   assign bus.busy    = busy_q;
   assign bus.halted  = halted_q;
endmodule

// File: tb/tb_cpu_step_core.sv
// Directed + randomized bench for cpu_step_core against an instruction-level reference model.
module tb_cpu_step_core;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [15:0] imem [0:255];
   logic [7:0]  m_regs [0:7];
   logic [7:0]  m_pc;
   logic        m_halted;

   cpu_step_core_if bus ();
   assign bus.im_data = imem[bus.im_addr];

   cpu_step_core #(.RST_PC(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] exp_rf();
      return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_pc     = 8'h00;
      m_halted = 1'b0;
   endtask

   // One instruction, straight from the ISA description.
   task automatic model_exec(input logic [15:0] ins);
      logic [3:0] op;
      logic [2:0] rd, rs, rt;
      logic [7:0] imm, r;
      int         wr;
      op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3]; imm = ins[7:0];
      wr = 1;
      r  = 8'h00;
      case (op)
         4'h1: r = imm;
         4'h2: r = 8'((int'(m_regs[rs]) + int'(m_regs[rt])) % 256);
         4'h3: r = 8'((int'(m_regs[rs]) - int'(m_regs[rt]) + 256) % 256);
         4'h4: r = m_regs[rs] & m_regs[rt];
         4'h5: r = m_regs[rs] | m_regs[rt];
         default: wr = 0;
      endcase
      if (wr == 1 && rd < 3'd5) m_regs[rd] = r;
      if (op == 4'h6)                         m_pc = imm;
      else if (op == 4'h7 && m_regs[rd] == 0) m_pc = imm;
      else if (op == 4'hF)                    m_halted = 1'b1;
      else                                    m_pc = 8'((int'(m_pc) + 1) % 256);
   endtask

   task automatic run_step(input logic [15:0] ins, input string tag);
      logic [15:0] prev_ir;
      prev_ir = bus.ir;
      imem[m_pc] = ins;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk) #1 bus.start = 1'b0;
      check({tag, ".busy_k"}, 64'(bus.busy), 64'(1));
      check({tag, ".ir_k"}, 64'(bus.ir), 64'(prev_ir));
      @(posedge clk) #1;
      check({tag, ".ir_k1"}, 64'(bus.ir), 64'(ins));
      @(posedge clk) #1;
      @(posedge clk) #1;
      check({tag, ".busy_k3"}, 64'(bus.busy), 64'(1));
      check({tag, ".pc_k3"}, 64'(bus.pc), 64'(m_pc));
      model_exec(ins);
      @(posedge clk) #1;
      check({tag, ".pc"}, 64'(bus.pc), 64'(m_pc));
      check({tag, ".rf"}, 64'(bus.rf_data), 64'(exp_rf()));
      check({tag, ".busy_k4"}, 64'(bus.busy), 64'(0));
      check({tag, ".halted"}, 64'(bus.halted), 64'(m_halted));
      check({tag, ".im_addr"}, 64'(bus.im_addr), 64'(m_pc));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".pc"}, 64'(bus.pc), 64'(8'h00));
      check({tag, ".ir"}, 64'(bus.ir), 64'(16'h0000));
      check({tag, ".rf"}, 64'(bus.rf_data), 64'(40'h0));
      check({tag, ".busy"}, 64'(bus.busy), 64'(0));
      check({tag, ".halted"}, 64'(bus.halted), 64'(0));
   endtask

   initial begin
      logic [15:0] ins;
      logic [7:0]  a1;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      bus.start = 1'b0;
`ifdef CPU_FREE_RUN_EN
      bus.run = 1'b0;
`endif
      model_reset();
      rst = 1'b1;
      #1 check_reset_state("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      run_step(16'h125A, "ldi_r1_5a");
      check("ldi_r1_val", 64'(bus.rf_data[15:8]), 64'(8'h5A));
      check("ldi_pc_01", 64'(bus.pc), 64'(8'h01));

      run_step(16'h1205, "ldi_r1_05");
      run_step(16'h1407, "ldi_r2_07");
      run_step(16'h3650, "sub_r3");
      check("sub_r3_fe", 64'(bus.rf_data[31:24]), 64'(8'hFE));
      run_step(16'h12FF, "ldi_r1_ff");
      run_step(16'h1401, "ldi_r2_01");
      run_step(16'h2850, "add_r4");
      check("add_wrap_00", 64'(bus.rf_data[39:32]), 64'(8'h00));

      run_step(16'h7040, "jz_taken");
      check("jz_taken_pc", 64'(bus.pc), 64'(8'h40));
      run_step(16'h1001, "ldi_r0_01");
      run_step(16'h7040, "jz_not");
      check("jz_not_pc", 64'(bus.pc), 64'(8'h42));
      run_step(16'h60FF, "jmp_ff");
      run_step(16'h1433, "ldi_at_ff");
      check("pc_wrap", 64'(bus.pc), 64'(8'h00));
      run_step(16'h1A77, "ldi_r5_discard");
      run_step(16'h2BC0, "add_reads_r7");
      run_step(16'h9ABC, "op9_nop");

      // start held for 10 cycles: accepted at k and k+5 only.
      imem[m_pc] = 16'h1211;
      a1 = 8'((int'(m_pc) + 1) % 256);
      imem[a1] = 16'h1422;
      @(negedge clk) bus.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk) #1;
         check($sformatf("held.busy%0d", i), 64'(bus.busy), 64'((i % 5) != 4));
         if (i == 4) model_exec(16'h1211);
         if (i == 9) model_exec(16'h1422);
      end
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("held.pc", 64'(bus.pc), 64'(m_pc));
      check("held.rf", 64'(bus.rf_data), 64'(exp_rf()));
      check("held.busy_end", 64'(bus.busy), 64'(0));

      for (int n = 0; n < 40; n++) begin
         ins = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_step(ins, $sformatf("rand%0d", n));
      end

`ifdef CPU_FREE_RUN_EN
      imem[m_pc] = 16'h1231;
      a1 = 8'((int'(m_pc) + 1) % 256);
      imem[a1] = 16'h1432;
      a1 = 8'((int'(m_pc) + 2) % 256);
      imem[a1] = 16'h1633;
      bus.run = 1'b1;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk) #1 bus.start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         for (int c = 1; c <= 4; c++) begin
            @(posedge clk) #1;
            if (c < 4) check($sformatf("run%0d.busy%0d", j, c), 64'(bus.busy), 64'(1));
         end
         model_exec(imem[m_pc]);
         check($sformatf("run%0d.pc", j), 64'(bus.pc), 64'(m_pc));
         check($sformatf("run%0d.rf", j), 64'(bus.rf_data), 64'(exp_rf()));
         check($sformatf("run%0d.busy_wb", j), 64'(bus.busy), 64'(j < 2));
         if (j == 1) bus.run = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("run.idle_busy", 64'(bus.busy), 64'(0));
      check("run.idle_pc", 64'(bus.pc), 64'(m_pc));
`endif

      // Reset during EXEC of an ADD discards the step.
      imem[m_pc] = 16'h2250;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk) #1 bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk) #1 rst = 1'b1;
      #1 check_reset_state("rst_exec");
      model_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      check_reset_state("rst_exec_after");

      run_step(16'h1207, "post_rst_ldi");
      run_step(16'hF000, "hlt");
      check("hlt_halted", 64'(bus.halted), 64'(1));
      check("hlt_pc", 64'(bus.pc), 64'(8'h01));
      imem[m_pc] = 16'h1255;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) bus.start = 1'b1;
         @(negedge clk) bus.start = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         check($sformatf("halt%0d.busy", i), 64'(bus.busy), 64'(0));
         check($sformatf("halt%0d.pc", i), 64'(bus.pc), 64'(m_pc));
         check($sformatf("halt%0d.ir", i), 64'(bus.ir), 64'(16'hF000));
         check($sformatf("halt%0d.rf", i), 64'(bus.rf_data), 64'(exp_rf()));
         check($sformatf("halt%0d.halted", i), 64'(bus.halted), 64'(1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
